checkout_monitor: RTL and testbench

- Downstream stage of the UPC marker logic. Consumes the marker's discount (d) and stolen (s) flags on each operator scan press.
- Keeps running item, discount and stolen counts, and runs a timed, blinking theft alarm.
- Sits between the marker and the board LEDR/HEX drivers in DE1_SoC.
- All inputs are asynchronous board signals and are synchronised internally.

---
 rtl/checkout_pkg.sv | 12 +
 rtl/checkout_monitor_edge_sync.sv | 29 ++
 rtl/checkout_monitor.sv | 158 +++++++++++++++
 tb/tb_checkout_monitor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/checkout_pkg.sv
// Shared types and constants for the checkout monitor: FSM state encoding
// and the synchroniser depth used by every board input.
package checkout_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ALARM = 1'b1
    } state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/checkout_monitor_edge_sync.sv
// Multi-flop synchroniser for one asynchronous board key, plus a rising-edge
// detector so a held key yields a single one-cycle pulse.
module edge_sync
    import checkout_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic in_raw,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_raw};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign rise  = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/checkout_monitor.sv
// Checkout monitor: counts accepted scans, discounts and thefts, and runs a
// timed blinking theft alarm that the operator can acknowledge.
module checkout_monitor
    import checkout_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int ALARM_LEN  = 250000000,
    parameter int BLINK_HALF = 12500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scan_raw,
    input  logic             ack_raw,
    input  logic             clear_raw,
    input  logic             d_in,
    input  logic             s_in,
    output logic [CNT_W-1:0] item_count,
    output logic [CNT_W-1:0] discount_count,
    output logic [CNT_W-1:0] stolen_count,
    output logic             accept,
    output logic             reject,
    output logic             alarm,
    output logic             blink
);

    localparam int AT_W = $clog2(ALARM_LEN + 1);
    localparam int BT_W = $clog2(BLINK_HALF + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [AT_W-1:0]  ALARM_LOAD = AT_W'(ALARM_LEN - 1);
    localparam logic [BT_W-1:0]  BLINK_LOAD = BT_W'(BLINK_HALF - 1);

    // Key index: 0 = scan, 1 = ack, 2 = clear
    logic [2:0] key_raw;
    logic [2:0] key_rise;
    logic [2:0] unused_key_level;
    // Flag index: 0 = discount, 1 = stolen
    logic [1:0] flag_raw;
    logic [1:0] flag_level;

    assign key_raw  = {clear_raw, ack_raw, scan_raw};
    assign flag_raw = {s_in, d_in};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_key_sync
            edge_sync u_edge_sync (
                .clk    (clk),
                .reset  (reset),
                .in_raw (key_raw[gi]),
                .level  (unused_key_level[gi]),
                .rise   (key_rise[gi])
            );
        end

        // Same depth as the key path so d/s line up with the scan pulse.
        for (genvar gi = 0; gi < 2; gi++) begin : g_flag_sync
            logic [SYNC_STAGES-1:0] sync_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], flag_raw[gi]};
                end
            end
            assign flag_level[gi] = sync_reg[SYNC_STAGES-1];
        end
    endgenerate

    logic scan_pulse, ack_pulse, clear_pulse, d_sync, s_sync;
    assign scan_pulse  = key_rise[0];
    assign ack_pulse   = key_rise[1];
    assign clear_pulse = key_rise[2];
    assign d_sync      = flag_level[0];
    assign s_sync      = flag_level[1];

    state_t           state_reg;
    logic [CNT_W-1:0] item_reg, discount_reg, stolen_reg;
    logic [AT_W-1:0]  alarm_timer_reg;
    logic [BT_W-1:0]  blink_timer_reg;
    logic             accept_reg, reject_reg, blink_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            item_reg        <= '0;
            discount_reg    <= '0;
            stolen_reg      <= '0;
            alarm_timer_reg <= '0;
            blink_timer_reg <= '0;
            accept_reg      <= 1'b0;
            reject_reg      <= 1'b0;
            blink_reg       <= 1'b0;
        end else begin
            accept_reg <= 1'b0;
            reject_reg <= 1'b0;
            if (clear_pulse) begin
                state_reg       <= IDLE;
                item_reg        <= '0;
                discount_reg    <= '0;
                stolen_reg      <= '0;
                alarm_timer_reg <= '0;
                blink_timer_reg <= '0;
                blink_reg       <= 1'b0;
            end else if (state_reg == ALARM) begin
                if (ack_pulse) begin
                    state_reg       <= IDLE;
                    alarm_timer_reg <= '0;
                    blink_timer_reg <= '0;
                    blink_reg       <= 1'b0;
                end else begin
                    // A scan during the alarm is refused but the timers keep running.
                    if (scan_pulse) begin
                        reject_reg <= 1'b1;
                    end
                    if (alarm_timer_reg == '0) begin
                        state_reg       <= IDLE;
                        blink_timer_reg <= '0;
                        blink_reg       <= 1'b0;
                    end else begin
                        alarm_timer_reg <= alarm_timer_reg - 1'b1;
                        if (blink_timer_reg == '0) begin
                            blink_reg       <= ~blink_reg;
                            blink_timer_reg <= BLINK_LOAD;
                        end else begin
                            blink_timer_reg <= blink_timer_reg - 1'b1;
                        end
                    end
                end
            end else if (scan_pulse) begin
                accept_reg <= 1'b1;
                // Saturating counts keep discount_count <= item_count.
                if (item_reg != CNT_MAX) begin
                    item_reg <= item_reg + 1'b1;
                end
                if (d_sync && discount_reg != CNT_MAX) begin
                    discount_reg <= discount_reg + 1'b1;
                end
                if (s_sync) begin
                    if (stolen_reg != CNT_MAX) begin
                        stolen_reg <= stolen_reg + 1'b1;
                    end
                    state_reg       <= ALARM;
                    alarm_timer_reg <= ALARM_LOAD;
                    blink_timer_reg <= BLINK_LOAD;
                    blink_reg       <= 1'b1;
                end
            end
        end
    end

    assign item_count     = item_reg;
    assign discount_count = discount_reg;
    assign stolen_count   = stolen_reg;
    assign accept         = accept_reg;
    assign reject         = reject_reg;
    assign alarm          = (state_reg == ALARM);
    assign blink          = blink_reg;

endmodule

// File: tb/tb_checkout_monitor.sv
// Scoreboard bench for checkout_monitor: stimulus pushes expected accept/reject
// events, a negedge monitor pops and compares them; direct probes cover timing.
module tb_checkout_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scan_raw = 1'b0, ack_raw = 1'b0, clear_raw = 1'b0;
    logic       d_in = 1'b0, s_in = 1'b0;
    logic [3:0] item_count, discount_count, stolen_count;
    logic       accept, reject, alarm, blink;

    typedef struct {
        logic       is_acc;
        logic [3:0] item;
        logic [3:0] disc;
        logic [3:0] stolen;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    checkout_monitor #(
        .CNT_W      (4),
        .ALARM_LEN  (8),
        .BLINK_HALF (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .scan_raw       (scan_raw),
        .ack_raw        (ack_raw),
        .clear_raw      (clear_raw),
        .d_in           (d_in),
        .s_in           (s_in),
        .item_count     (item_count),
        .discount_count (discount_count),
        .stolen_count   (stolen_count),
        .accept         (accept),
        .reject         (reject),
        .alarm          (alarm),
        .blink          (blink)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_acc, input int item, input int disc, input int stolen);
        exp_t e;
        e.is_acc = is_acc;
        e.item   = 4'(item);
        e.disc   = 4'(disc);
        e.stolen = 4'(stolen);
        exp_q.push_back(e);
    endtask

    // key: 0 = scan, 1 = ack, 2 = clear; held three cycles then released three.
    task automatic press(input int key);
        case (key)
            0: scan_raw = 1'b1;
            1: ack_raw = 1'b1;
            default: clear_raw = 1'b1;
        endcase
        step(3);
        scan_raw = 1'b0; ack_raw = 1'b0; clear_raw = 1'b0;
        step(3);
    endtask

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    // Monitor: every accept/reject the DUT shows must match the next queued event.
    always @(negedge clk) begin
        if (reset && (accept || reject)) begin
            exp_t e;
            check("accept_reject_exclusive", {31'd0, accept & reject}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_event", {28'd0, accept, reject, item_count[1:0]}, 32'hffff);
            end else begin
                e = exp_q.pop_front();
                $display("event %s item=%0d disc=%0d stolen=%0d", accept ? "accept" : "reject",
                         item_count, discount_count, stolen_count);
                check("event", {19'd0, accept, item_count, discount_count, stolen_count},
                      {19'd0, e.is_acc, e.item, e.disc, e.stolen});
            end
        end
    end

    logic [7:0] blink_pat;

    initial begin
        blink_pat = 8'b1100_1100;

        // Reset state
        step(2);
        check("reset_item", {28'd0, item_count}, 32'd0);
        check("reset_outs", {28'd0, accept, reject, alarm, blink}, 32'd0);
        reset = 1'b1;
        step(2);

        // Single scan d=1: latency of three edges
        d_in = 1'b1; s_in = 1'b0;
        push(1'b1, 1, 1, 0);
        scan_raw = 1'b1;
        step(2);
        check("lat_edge2_accept", {31'd0, accept}, 32'd0);
        step(1);
        check("lat_edge3_accept", {31'd0, accept}, 32'd1);
        check("scan1_counts", {20'd0, item_count, discount_count, stolen_count}, 32'h110);
        check("scan1_alarm", {31'd0, alarm}, 32'd0);
        scan_raw = 1'b0;
        step(1);
        check("accept_one_cycle", {31'd0, accept}, 32'd0);
        step(3);

        // Held key yields one event
        d_in = 1'b0;
        push(1'b1, 2, 1, 0);
        scan_raw = 1'b1;
        step(20);
        check("held_item", {28'd0, item_count}, 32'd2);
        scan_raw = 1'b0;
        step(3);
        push(1'b1, 3, 1, 0);
        press(0);

        // Stolen scan: alarm with blink pattern
        s_in = 1'b1;
        push(1'b1, 4, 1, 1);
        scan_raw = 1'b1;
        step(3);
        scan_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("alarm_on", {31'd0, alarm}, 32'd1);
            check("blink_pat", {31'd0, blink}, {31'd0, blink_pat[7-i]});
            step(1);
        end
        check("alarm_end", {30'd0, alarm, blink}, 32'd0);
        step(3);

        // Scan during alarm is rejected
        push(1'b1, 5, 1, 2);
        press(0);
        s_in = 1'b0;
        push(1'b0, 5, 1, 2);
        press(0);
        step(8);
        check("alarm_timeout", {31'd0, alarm}, 32'd0);

        // Ack at alarm cycle 3
        s_in = 1'b1;
        push(1'b1, 6, 1, 3);
        scan_raw = 1'b1;
        step(3);
        scan_raw = 1'b0;
        step(2);
        ack_raw = 1'b1;
        step(2);
        check("ack_edge2_alarm", {31'd0, alarm}, 32'd1);
        step(1);
        check("ack_edge3_alarm", {30'd0, alarm, blink}, 32'd0);
        ack_raw = 1'b0;
        step(3);

        // Same-cycle scan + ack in alarm: ack wins, no reject
        push(1'b1, 7, 1, 4);
        press(0);
        s_in = 1'b0;
        scan_raw = 1'b1; ack_raw = 1'b1;
        step(3);
        check("scan_ack_alarm", {31'd0, alarm}, 32'd0);
        scan_raw = 1'b0; ack_raw = 1'b0;
        step(3);

        // Clear
        clear_raw = 1'b1;
        step(2);
        check("clear_edge2_item", {28'd0, item_count}, 32'd7);
        step(1);
        check("clear_counts", {20'd0, item_count, discount_count, stolen_count}, 32'd0);
        clear_raw = 1'b0;
        step(3);

        // Saturation at 15
        d_in = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            push(1'b1, sat15(i), sat15(i), 0);
            press(0);
        end
        check("sat_counts", {24'd0, item_count, discount_count}, 32'hff);
        press(2);
        check("clear2_counts", {20'd0, item_count, discount_count, stolen_count}, 32'd0);

        // Simultaneous clear + scan
        push(1'b1, 1, 1, 0);
        press(0);
        scan_raw = 1'b1; clear_raw = 1'b1;
        step(3);
        check("clear_scan_counts", {20'd0, item_count, discount_count, stolen_count}, 32'd0);
        check("clear_scan_accept", {31'd0, accept}, 32'd0);
        scan_raw = 1'b0; clear_raw = 1'b0;
        step(3);

        // Reset mid-alarm is asynchronous
        d_in = 1'b0; s_in = 1'b1;
        push(1'b1, 1, 0, 1);
        scan_raw = 1'b1;
        step(3);
        scan_raw = 1'b0;
        step(2);
        check("pre_reset_alarm", {31'd0, alarm}, 32'd1);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_outs", {30'd0, alarm, blink}, 32'd0);
        check("async_reset_counts", {20'd0, item_count, discount_count, stolen_count}, 32'd0);
        step(2);
        reset = 1'b1;
        step(3);
        check("post_reset_alarm", {31'd0, alarm}, 32'd0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
